// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bundle: redirect/stall controls from later stages, ROM port, and IF/ID outputs to decode.
// The fetch stage uses the slave modport; the control/ROM side uses master.
interface mips_fetch_stage_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   Stall;
  logic                   Flush;
  logic                   BranchTaken;
  logic [DATA_WIDTH-1:0]  BranchTarget;
  logic                   Jump;
  logic [DATA_WIDTH-1:0]  JumpTarget;
  logic                   JR;
  logic [DATA_WIDTH-1:0]  JRTarget;
  logic [DATA_WIDTH-1:0]  ROMAddress;
  logic [DATA_WIDTH-1:0]  ROMInstruction;
  logic [DATA_WIDTH-1:0]  PCValue;
  logic [DATA_WIDTH-1:0]  IF_ID_Instr;
  logic [DATA_WIDTH-1:0]  IF_ID_PC4;
  logic                   IF_ID_Valid;
  logic [COUNT_WIDTH-1:0] FetchCount;
  logic                   AddrFault;
  logic                   MisalignFault;

  modport master (
    output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, JR, JRTarget, ROMInstruction,
    input  ROMAddress, PCValue, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, FetchCount, AddrFault, MisalignFault
  );

  modport slave (
    input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, JR, JRTarget, ROMInstruction,
    output ROMAddress, PCValue, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, FetchCount, AddrFault, MisalignFault
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// Instruction fetch: PC register with prioritised redirect (JR > Jump > Branch) feeding an IF/ID register.
// One clock from PC to IF/ID; Stall holds PC and IF/ID, but a redirect from a later stage overrides it.
module mips_fetch_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(32'h0040_0000),
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(32'h0040_0000),
  parameter int                    COUNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset,
  mips_fetch_stage_if.slave fetchBus
);
  // One extra bit so a ROM ending at the top of the address space does not wrap the limit.
  localparam logic [DATA_WIDTH:0] TEXT_LIMIT = {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0]  pc;
  logic [DATA_WIDTH-1:0]  pcPlus4;
  logic [DATA_WIDTH-1:0]  rawTarget;
  logic [DATA_WIDTH-1:0]  ifIdInstr;
  logic [DATA_WIDTH-1:0]  ifIdPc4;
  logic                   ifIdValid;
  logic [COUNT_WIDTH-1:0] fetchCount;
  logic                   addrFault;
  logic                   misalignFault;
  logic                   redirect;
  logic                   inRange;
  logic                   loadValid;

  always_comb begin
    rawTarget = fetchBus.BranchTarget;
    if (fetchBus.JR)
      rawTarget = fetchBus.JRTarget;
    else if (fetchBus.Jump)
      rawTarget = fetchBus.JumpTarget;
  end

  assign redirect  = fetchBus.JR | fetchBus.Jump | fetchBus.BranchTaken;
  assign pcPlus4   = pc + DATA_WIDTH'(4);
  assign inRange   = (pc >= TEXT_BASE) && ({1'b0, pc} < TEXT_LIMIT);
  assign loadValid = !redirect && !fetchBus.Flush && !fetchBus.Stall && inRange;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else if (redirect)
      pc <= {rawTarget[DATA_WIDTH-1:2], 2'b00};
    else if (!fetchBus.Stall)
      pc <= pcPlus4;
  end

  // No delay slot: the instruction fetched alongside a redirect is squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifIdInstr <= '0;
      ifIdPc4   <= '0;
      ifIdValid <= 1'b0;
    end else if (redirect || fetchBus.Flush || (!fetchBus.Stall && !inRange)) begin
      ifIdInstr <= '0;
      ifIdValid <= 1'b0;
    end else if (!fetchBus.Stall) begin
      ifIdInstr <= fetchBus.ROMInstruction;
      ifIdPc4   <= pcPlus4;
      ifIdValid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchCount    <= '0;
      addrFault     <= 1'b0;
      misalignFault <= 1'b0;
    end else begin
      if (loadValid && !(&fetchCount))
        fetchCount <= fetchCount + 1'b1;
      if (!redirect && !fetchBus.Stall && !inRange)
        addrFault <= 1'b1;
      if (redirect && (rawTarget[1:0] != 2'b00))
        misalignFault <= 1'b1;
    end
  end

  assign fetchBus.ROMAddress    = pc;
  assign fetchBus.PCValue       = pc;
  assign fetchBus.IF_ID_Instr   = ifIdInstr;
  assign fetchBus.IF_ID_PC4     = ifIdPc4;
  assign fetchBus.IF_ID_Valid   = ifIdValid;
  assign fetchBus.FetchCount    = fetchCount;
  assign fetchBus.AddrFault     = addrFault;
  assign fetchBus.MisalignFault = misalignFault;
endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: sequential ROM model, hand-computed PC / IF/ID / counter / fault values.
module tb_mips_fetch_stage;
  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  mips_fetch_stage_if #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) fetchBus ();

  mips_fetch_stage #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(32),
    .RESET_PC    (32'h0040_0000),
    .TEXT_BASE   (32'h0040_0000),
    .COUNT_WIDTH (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fetchBus(fetchBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word i holds C0DE0000 + i
  always_comb fetchBus.ROMInstruction = 32'hC0DE_0000 | ((fetchBus.ROMAddress - 32'h0040_0000) >> 2);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic valid, input int count);
    checkVal({tag, ".pc"},    fetchBus.PCValue, pc);
    checkVal({tag, ".rom"},   fetchBus.ROMAddress, pc);
    checkVal({tag, ".instr"}, fetchBus.IF_ID_Instr, instr);
    checkVal({tag, ".valid"}, 32'(fetchBus.IF_ID_Valid), 32'(valid));
    checkVal({tag, ".count"}, 32'(fetchBus.FetchCount), 32'(count));
  endtask

  task automatic checkReset(input string tag);
    checkState(tag, 32'h0040_0000, 32'h0, 1'b0, 0);
    checkVal({tag, ".pc4"}, fetchBus.IF_ID_PC4, 32'h0);
    checkVal({tag, ".af"},  32'(fetchBus.AddrFault), 32'h0);
    checkVal({tag, ".mf"},  32'(fetchBus.MisalignFault), 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearControls();
    fetchBus.Stall       = 1'b0;
    fetchBus.Flush       = 1'b0;
    fetchBus.BranchTaken = 1'b0;
    fetchBus.Jump        = 1'b0;
    fetchBus.JR          = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    clearControls();
    fetchBus.BranchTarget = 32'h0;
    fetchBus.JumpTarget   = 32'h0;
    fetchBus.JRTarget     = 32'h0;
    #3;
    checkReset("reset");
    #4;
    reset = 1'b0;

    step(); checkState("seq0", 32'h0040_0004, 32'hC0DE_0000, 1'b1, 1);
    checkVal("seq0.pc4", fetchBus.IF_ID_PC4, 32'h0040_0004);
    step(); checkState("seq1", 32'h0040_0008, 32'hC0DE_0001, 1'b1, 2);

    fetchBus.Stall = 1'b1;
    step(); checkState("stall0", 32'h0040_0008, 32'hC0DE_0001, 1'b1, 2);
    step(); checkState("stall1", 32'h0040_0008, 32'hC0DE_0001, 1'b1, 2);
    fetchBus.Stall = 1'b0;
    step(); checkState("resume", 32'h0040_000C, 32'hC0DE_0002, 1'b1, 3);
    checkVal("resume.pc4", fetchBus.IF_ID_PC4, 32'h0040_000C);

    // All three redirects plus Stall: JR must win
    fetchBus.Stall = 1'b1;
    fetchBus.JR = 1'b1;          fetchBus.JRTarget     = 32'h0040_0040;
    fetchBus.Jump = 1'b1;        fetchBus.JumpTarget   = 32'h0040_0020;
    fetchBus.BranchTaken = 1'b1; fetchBus.BranchTarget = 32'h0040_0030;
    step(); checkState("prio", 32'h0040_0040, 32'h0, 1'b0, 3);
    checkVal("prio.pc4", fetchBus.IF_ID_PC4, 32'h0040_000C);
    checkVal("prio.mf", 32'(fetchBus.MisalignFault), 32'h0);
    clearControls();
    step(); checkState("afterJr", 32'h0040_0044, 32'hC0DE_0010, 1'b1, 4);

    fetchBus.Flush = 1'b1;
    step(); checkState("flush", 32'h0040_0048, 32'h0, 1'b0, 4);
    checkVal("flush.pc4", fetchBus.IF_ID_PC4, 32'h0040_0044);
    clearControls();

    fetchBus.BranchTaken = 1'b1; fetchBus.BranchTarget = 32'h0040_0013;
    step(); checkState("misalign", 32'h0040_0010, 32'h0, 1'b0, 4);
    checkVal("misalign.mf", 32'(fetchBus.MisalignFault), 32'h1);
    clearControls();
    step(); checkState("afterBr", 32'h0040_0014, 32'hC0DE_0004, 1'b1, 5);
    checkVal("afterBr.mf", 32'(fetchBus.MisalignFault), 32'h1);

    fetchBus.Jump = 1'b1; fetchBus.JumpTarget = 32'h0040_0078;
    step(); checkState("jmpEnd", 32'h0040_0078, 32'h0, 1'b0, 5);
    clearControls();
    step(); checkState("last1", 32'h0040_007C, 32'hC0DE_001E, 1'b1, 6);
    checkVal("last1.af", 32'(fetchBus.AddrFault), 32'h0);
    step(); checkState("last0", 32'h0040_0080, 32'hC0DE_001F, 1'b1, 7);
    checkVal("last0.af", 32'(fetchBus.AddrFault), 32'h0);
    step(); checkState("oor0", 32'h0040_0084, 32'h0, 1'b0, 7);
    checkVal("oor0.af", 32'(fetchBus.AddrFault), 32'h1);
    step(); checkState("oor1", 32'h0040_0088, 32'h0, 1'b0, 7);

    fetchBus.Jump = 1'b1; fetchBus.JumpTarget = 32'h0040_0000;
    step(); checkState("recover", 32'h0040_0000, 32'h0, 1'b0, 7);
    clearControls();
    step(); checkState("recovered", 32'h0040_0004, 32'hC0DE_0000, 1'b1, 8);
    checkVal("recovered.af", 32'(fetchBus.AddrFault), 32'h1);

    // 8 + 9 loads would be 17: must saturate at 15
    for (int i = 0; i < 9; i++) step();
    checkState("saturate", 32'h0040_0028, 32'hC0DE_0009, 1'b1, 15);

    fetchBus.Jump = 1'b1; fetchBus.JumpTarget = 32'hFFFF_FFFC;
    step(); checkState("top", 32'hFFFF_FFFC, 32'h0, 1'b0, 15);
    clearControls();
    step(); checkState("wrap", 32'h0000_0000, 32'h0, 1'b0, 15);

    fetchBus.Stall = 1'b1;
    step(); checkState("preRst", 32'h0000_0000, 32'h0, 1'b0, 15);
    #2;
    reset = 1'b1;
    fetchBus.JR = 1'b1; fetchBus.JRTarget = 32'h0040_0040;
    #1;
    checkReset("midRst");
    step();
    checkReset("heldRst");
    clearControls();
    reset = 1'b0;
    step(); checkState("postRst", 32'h0040_0004, 32'hC0DE_0000, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
